// File: rtl/riscv_lsu.sv
// Load/store unit between the execute stage and a variable-latency data memory.
// One access at a time: issue in IDLE, wait for the memory ack in WAIT, and
// give the core a single non-stalled retire cycle in DONE. Misaligned or
// illegal-size requests never reach memory and report a one-cycle error.
//
// Handshake: data_req_o is a one-cycle strobe with data_we_o/data_be_o/
// data_addr_o/data_wdata_o valid alongside it (all zero otherwise); the memory
// completes the access with a single-cycle data_rvalid_i pulse at least one
// cycle later. data_rvalid_i is only honoured in WAIT.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i,
  output logic [1:0]  dbg_state_o
);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  // The WAIT cycle in which the counter holds this value is the last one; the
  // counter would reach TIMEOUT_CYCLES-1 on that edge, so the core sees
  // exactly TIMEOUT_CYCLES stalled cycles before the abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic        we_q;

  logic        fault;
  logic        issue;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] lane_b;
  logic [31:0] lane_h;
  logic [31:0] load_ext;

  // Alignment / size legality of the request currently offered by the core.
  always_comb begin
    fault = 1'b0;
    case (lsu_size_i)
      SZ_B, SZ_BU: fault = 1'b0;
      SZ_H, SZ_HU: fault = lsu_addr_i[0];
      SZ_W:        fault = |lsu_addr_i[1:0];
      default:     fault = 1'b1;
    endcase
  end

  assign issue = (state == ST_IDLE) && lsu_req_i && !fault;

  // Byte-enable and lane-replicated store data for the offered request.
  always_comb begin
    be_fmt    = 4'b0000;
    wdata_fmt = 32'h0;
    case (lsu_size_i)
      SZ_B, SZ_BU: begin
        be_fmt    = 4'b0001 << lsu_addr_i[1:0];
        wdata_fmt = {4{lsu_data_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        be_fmt    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_fmt = {2{lsu_data_i[15:0]}};
      end
      SZ_W: begin
        be_fmt    = 4'b1111;
        wdata_fmt = lsu_data_i;
      end
      default: begin
        be_fmt    = 4'b0000;
        wdata_fmt = 32'h0;
      end
    endcase
  end

  // Memory-side request: only meaningful (and only non-zero) during the issue cycle.
  always_comb begin
    data_req_o      = issue;
    data_we_o       = issue & lsu_we_i;
    data_be_o       = issue ? be_fmt : 4'b0000;
    data_addr_o     = issue ? {lsu_addr_i[31:2], 2'b00} : 32'h0;
    data_wdata_o    = issue ? wdata_fmt : 32'h0;
    lsu_stall_req_o = issue | (state == ST_WAIT);
  end

  // Select the addressed lane of the returned word and extend it to 32 bits.
  always_comb begin
    lane_b   = data_rdata_i >> {off_q, 3'b000};
    lane_h   = data_rdata_i >> {off_q[1], 4'b0000};
    load_ext = data_rdata_i;
    case (size_q)
      SZ_B:    load_ext = {{24{lane_b[7]}}, lane_b[7:0]};
      SZ_BU:   load_ext = {24'h0, lane_b[7:0]};
      SZ_H:    load_ext = {{16{lane_h[15]}}, lane_h[15:0]};
      SZ_HU:   load_ext = {16'h0, lane_h[15:0]};
      default: load_ext = data_rdata_i;
    endcase
  end

  assign dbg_state_o = state;

  // Access sequencing, timeout counter, latched request fields and registered results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      off_q      <= 2'd0;
      size_q     <= 3'd0;
      we_q       <= 1'b0;
      lsu_data_o <= 32'h0;
      lsu_err_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          lsu_err_o <= 1'b0;
          if (lsu_req_i) begin
            if (fault) begin
              lsu_err_o <= 1'b1;
              state     <= ST_DONE;
            end else begin
              off_q  <= lsu_addr_i[1:0];
              size_q <= lsu_size_i;
              we_q   <= lsu_we_i;
              cnt    <= 8'd0;
              state  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 8'd1;
          if (data_rvalid_i) begin
            if (!we_q) begin
              lsu_data_o <= load_ext;
            end
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            lsu_data_o <= 32'h0;
            lsu_err_o  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          lsu_err_o <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          lsu_err_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
